conv_weight_loader: RTL and testbench
=====================================

# conv_weight_loader

Streams one conv layer's pre-packed weight words from an on-chip weight memory into that layer's per-row weight buffers (`weight_buffer_wren` / `weight_buffer_din`), honouring the buffers' programmable-full backpressure. It sits directly upstream of each `conv_top` weight buffer in `VGG_CONV`, one instance per layer. It replays the whole layer weight set once per pass, so the PE array receives the same group sequence for every output-row tile.

## Interface
Parameters:
- `WH`, 4: rows per PE block, equal to the layer's `CONV_Wh`; width of wren/full.
- `WW`, 3: kernel width, equal to the layer's `CONV_Ww`.
- `DATA_WIDTH`, 8: bits per weight.
- `GROUP_WORDS`, 4: words per group, equal to ceil(N,WH)/WH.
- `ADDR_W`, 16: weight memory address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; accepted only in IDLE.
- `base_addr` in ADDR_W: address of word 0; sampled on an accepted start.
- `num_groups` in 16: groups per pass; sampled on start.
- `num_passes` in 16: pass count; sampled on start.
- `mem_rd_en` out 1: weight memory read strobe.
- `mem_addr` out ADDR_W: read address.
- `mem_rd_data` in WH*WW*DATA_WIDTH: read data, valid exactly 1 cycle after `mem_rd_en`.
- `weight_buffer_wren` out WH: all bits driven identically.
- `weight_buffer_din` out [WH-1:0][WW-1:0][DATA_WIDTH-1:0]: weight word.
- `weight_buffer_full` in WH: per-row prog_full.
- `busy` out 1: high from the cycle after an accepted start through DONE.
- `done` out 1: one-cycle pulse at the end of the layer.

## Operation
- FSM states IDLE, RUN, DRAIN, DONE. Transitions:
  - IDLE→RUN on start.
  - IDLE→DONE on start when num_groups==0 or num_passes==0. No reads are issued in this case.
  - RUN→DRAIN once the last read has been issued.
  - DRAIN→DONE when no read is in flight, the queue is empty, and the last word has been written.
  - DONE→IDLE unconditionally.
- Counters: `word_cnt` 0..GROUP_WORDS-1, `group_cnt` 0..num_groups-1, `pass_cnt` 0..num_passes-1.
  - `mem_addr` is a running pointer that increments per read.
  - The pointer reloads `base_addr` when group_cnt and word_cnt wrap at end of pass.
  - Total words = num_passes·num_groups·GROUP_WORDS.
- Address arithmetic wraps modulo 2^ADDR_W. No range check is performed.
- A 2-entry queue absorbs the 1-cycle read latency.
  - Read issue rule: a read is issued only if (queue entries + in-flight reads − pop this cycle) < 2.
  - The queue can never overflow under this rule.
- Write stage:
  - Pops the queue into registered `weight_buffer_wren` / `weight_buffer_din` when the queue is non-empty and |weight_buffer_full was 0 at the previous edge.
  - When no write occurs, wren='0 and din=0.
- Backpressure:
  - Any full bit high stalls the whole word. Rows are never written individually.
  - Each stall holds at most 2 buffered words plus 1 word already committed (consistent with prog_full headroom).
- start while not IDLE is ignored. Parameters latched at start are unaffected by later input changes.

## Timing
- Reset values: mem_rd_en=0, mem_addr=0, wren='0, din=0, busy=0, done=0. State=IDLE, counters=0, queue empty.
- Reset mid-operation discards the queue and any in-flight read. No further wren occurs after rst rises.
- Latency with start at cycle 0:
  - RUN and first mem_rd_en at cycle 1.
  - Data returns at cycle 2.
  - First wren at cycle 3.
- Throughput: steady 1 word/cycle with full low. No bubble at group or pass boundaries.
- Full rising at edge t: wren is low from cycle t+1 and resumes the cycle after full is sampled low.
- `done` is asserted in the DONE cycle, 1 cycle after the last wren with no stall. `busy` falls with DONE's exit.
- Zero-size start: done pulses at cycle 1.

## Configuration
- `WLOAD_CHECKSUM_EN` defined:
  - Adds output `checksum` [31:0], the sum of all written weight bytes modulo 2^32.
  - Cleared on accepted start. Stable from `done` until the next start.
- Undefined: the port and adder are absent. Behaviour is otherwise identical.

## Structure
- `parameter_package` holds the `wload_state_t` enum (IDLE, RUN, DRAIN, DONE) and the `WLOAD_QDEPTH=2` constant.
- One sub-module, `wload_skid_queue`: 2-entry FIFO with push/pop/count, parameterised by width.

## Test plan
- WH=4, WW=3, GROUP_WORDS=4, num_groups=2, num_passes=1, base=0x10, full low → reads 0x10..0x17 on cycles 1–8, wren cycles 3–10, done cycle 11.
- num_passes=3, num_groups=1 → 12 writes with addresses 0x10..0x13 repeated three times, no idle cycle between passes.
- Hold full[2] high for cycles 5–9 → no wren in cycles 6–10, zero words lost or duplicated, data order preserved.
- num_groups=0 → done at cycle 1, mem_rd_en never high.
- Assert rst at cycle 6 of a run → all outputs zero immediately, state IDLE; a restart then reproduces the run from word 0.
- With `WLOAD_CHECKSUM_EN`, memory filled with bytes 0x01 and 8 words of 12 bytes → checksum=96 at done.

Source files
------------

// File: rtl/conv_weight_loader_pkg.sv
// Shared types and constants for the conv layer weight loader.
package conv_weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wload_state_t;

  localparam int WLOAD_QDEPTH = 2;

endpackage

// File: rtl/conv_weight_loader_if.sv
// Weight-memory read port and per-row weight-buffer write port of the loader.
interface conv_weight_loader_if #(
  parameter int ADDR_W     = 16,
  parameter int WH         = 4,
  parameter int WW         = 3,
  parameter int DATA_WIDTH = 8
);
  logic                                      mem_rd_en;
  logic [ADDR_W-1:0]                         mem_addr;
  logic [WH*WW*DATA_WIDTH-1:0]               mem_rd_data;
  logic [WH-1:0]                             weight_buffer_wren;
  logic [WH-1:0][WW-1:0][DATA_WIDTH-1:0]     weight_buffer_din;
  logic [WH-1:0]                             weight_buffer_full;

  modport master (
    output mem_rd_en, mem_addr, weight_buffer_wren, weight_buffer_din,
    input  mem_rd_data, weight_buffer_full
  );

  modport slave (
    input  mem_rd_en, mem_addr, weight_buffer_wren, weight_buffer_din,
    output mem_rd_data, weight_buffer_full
  );
endinterface

// File: rtl/conv_weight_loader_skid_queue.sv
// Two-entry FIFO that absorbs the one-cycle weight memory read latency.
module wload_skid_queue
  import conv_weight_loader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [WLOAD_QDEPTH];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WLOAD_QDEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/conv_weight_loader.sv
// Replays a layer's packed weight words from weight memory into the per-row weight buffers.
// Optional WLOAD_CHECKSUM_EN adds a running byte-sum of all written weights.
module conv_weight_loader
  import conv_weight_loader_pkg::*;
#(
  parameter int WH          = 4,
  parameter int WW          = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int GROUP_WORDS = 4,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_groups,
  input  logic [15:0]       num_passes,
  conv_weight_loader_if.master bus,
  output logic              busy,
  output logic              done
`ifdef WLOAD_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int WORD_W = WH * WW * DATA_WIDTH;

  wload_state_t      state_r;
  logic [15:0]       word_cnt_r, group_cnt_r, pass_cnt_r;
  logic [15:0]       num_groups_r, num_passes_r;
  logic [ADDR_W-1:0] base_r, addr_ptr_r, mem_addr_r;
  logic              mem_rd_en_r, rd_valid_r, busy_r, done_r;
  logic [WH-1:0]     wren_r;
  logic [WORD_W-1:0] din_r;

  logic              idle_s, zero_size_s, full_any_s, pop_s, issue_s, drain_done_s;
  logic              last_word_s, last_group_s, last_pass_s, end_pass_s, last_read_s;
  logic [15:0]       cur_word_s, cur_group_s, cur_pass_s, cur_groups_s, cur_passes_s;
  logic [15:0]       nxt_word_s, nxt_group_s, nxt_pass_s;
  logic [ADDR_W-1:0] cur_ptr_s, cur_base_s, nxt_ptr_s;
  logic [2:0]        occ_s;
  logic              q_push_s, q_pop_s;
  logic [WORD_W-1:0] q_dout, head_data_s;
  logic [1:0]        q_count;

  wload_skid_queue #(.WIDTH(WORD_W)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push_s),
    .pop   (q_pop_s),
    .din   (bus.mem_rd_data),
    .dout  (q_dout),
    .count (q_count)
  );

  // Write-stage head selection: the returning read bypasses an empty queue
  always_comb begin
    full_any_s   = |bus.weight_buffer_full;
    pop_s        = ((q_count != 2'd0) || rd_valid_r) && !full_any_s;
    head_data_s  = (q_count != 2'd0) ? q_dout : bus.mem_rd_data;
    q_pop_s      = pop_s && (q_count != 2'd0);
    q_push_s     = rd_valid_r && !(pop_s && (q_count == 2'd0));
    occ_s        = 3'(q_count) + 3'(rd_valid_r) + 3'(mem_rd_en_r) - 3'(pop_s);
    drain_done_s = !mem_rd_en_r && !rd_valid_r && (q_count == 2'd0);
  end

  // Read sequencing; in IDLE the start inputs stand in for the latched values
  always_comb begin
    idle_s       = (state_r == IDLE);
    zero_size_s  = (num_groups == 16'd0) || (num_passes == 16'd0);
    cur_word_s   = idle_s ? 16'd0 : word_cnt_r;
    cur_group_s  = idle_s ? 16'd0 : group_cnt_r;
    cur_pass_s   = idle_s ? 16'd0 : pass_cnt_r;
    cur_groups_s = idle_s ? num_groups : num_groups_r;
    cur_passes_s = idle_s ? num_passes : num_passes_r;
    cur_ptr_s    = idle_s ? base_addr : addr_ptr_r;
    cur_base_s   = idle_s ? base_addr : base_r;
    last_word_s  = (cur_word_s == 16'(GROUP_WORDS - 1));
    last_group_s = (cur_group_s == cur_groups_s - 16'd1);
    last_pass_s  = (cur_pass_s == cur_passes_s - 16'd1);
    end_pass_s   = last_word_s && last_group_s;
    last_read_s  = end_pass_s && last_pass_s;
    nxt_word_s   = last_word_s ? 16'd0 : cur_word_s + 16'd1;
    nxt_group_s  = last_word_s ? (last_group_s ? 16'd0 : cur_group_s + 16'd1) : cur_group_s;
    nxt_pass_s   = end_pass_s ? cur_pass_s + 16'd1 : cur_pass_s;
    nxt_ptr_s    = end_pass_s ? cur_base_s : cur_ptr_s + ADDR_W'(1);
    if (idle_s) begin
      issue_s = start && !zero_size_s;
    end else begin
      issue_s = (state_r == RUN) && (occ_s < 3'd2);
    end
  end

  // Control FSM with registered read strobe, address, busy and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      word_cnt_r   <= 16'd0;
      group_cnt_r  <= 16'd0;
      pass_cnt_r   <= 16'd0;
      num_groups_r <= 16'd0;
      num_passes_r <= 16'd0;
      base_r       <= '0;
      addr_ptr_r   <= '0;
      mem_addr_r   <= '0;
      mem_rd_en_r  <= 1'b0;
      rd_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      mem_rd_en_r <= issue_s;
      rd_valid_r  <= mem_rd_en_r;
      done_r      <= 1'b0;
      if (issue_s) begin
        mem_addr_r  <= cur_ptr_s;
        addr_ptr_r  <= nxt_ptr_s;
        word_cnt_r  <= nxt_word_s;
        group_cnt_r <= nxt_group_s;
        pass_cnt_r  <= nxt_pass_s;
      end
      case (state_r)
        IDLE: begin
          busy_r <= 1'b0;
          if (start) begin
            base_r       <= base_addr;
            num_groups_r <= num_groups;
            num_passes_r <= num_passes;
            busy_r       <= 1'b1;
            if (zero_size_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else if (last_read_s) begin
              state_r <= DRAIN;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (issue_s && last_read_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Write stage: a stalled word stays queued rather than being split across rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_r <= '0;
      din_r  <= '0;
    end else if (pop_s) begin
      wren_r <= '1;
      din_r  <= head_data_s;
    end else begin
      wren_r <= '0;
      din_r  <= '0;
    end
  end

`ifdef WLOAD_CHECKSUM_EN
  function automatic logic [31:0] word_sum(input logic [WORD_W-1:0] w);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < WH * WW; i++) begin
      s = s + 32'(w[i*DATA_WIDTH +: DATA_WIDTH]);
    end
    return s;
  endfunction

  logic [31:0] checksum_r;

  // Running sum of every weight committed to the buffers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_r <= 32'd0;
    end else if (idle_s && start) begin
      checksum_r <= 32'd0;
    end else if (pop_s) begin
      checksum_r <= checksum_r + word_sum(head_data_s);
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

  assign bus.mem_rd_en          = mem_rd_en_r;
  assign bus.mem_addr           = mem_addr_r;
  assign bus.weight_buffer_wren = wren_r;
  assign bus.weight_buffer_din  = din_r;
  assign busy                   = busy_r;
  assign done                   = done_r;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Scoreboard bench for conv_weight_loader: a pass/group/word model predicts reads and writes.
module tb_conv_weight_loader;
  localparam int WH = 4, WW = 3, DW = 8, GW = 4, AW = 16, WORD_W = WH * WW * DW;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] base_addr = 16'd0, num_groups = 16'd0, num_passes = 16'd0;
  logic busy, done;
`ifdef WLOAD_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  logic [WH-1:0] full_dir = 4'd0, full_rnd = 4'd0;
  bit rand_full = 1'b0;

  conv_weight_loader_if #(.ADDR_W(AW), .WH(WH), .WW(WW), .DATA_WIDTH(DW)) bus ();
  assign bus.weight_buffer_full = full_dir | full_rnd;

  conv_weight_loader #(.WH(WH), .WW(WW), .DATA_WIDTH(DW), .GROUP_WORDS(GW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_groups(num_groups), .num_passes(num_passes), .bus(bus),
    .busy(busy), .done(done)
`ifdef WLOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  int n_rd, n_wr, first_rd, last_rd, first_wr, last_wr, done_rel, stall_wr;
  bit full_edge = 1'b0;
  bit ones_mode = 1'b0;
  logic [7:0] salt = 8'd0;
  logic [15:0] exp_rd_q[$];
  logic [WORD_W-1:0] exp_wr_q[$];
  logic [31:0] exp_cs = 32'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] mem_fn(input logic [15:0] a);
    logic [WORD_W-1:0] w;
    for (int k = 0; k < WH * WW; k++) begin
      w[k*8 +: 8] = ones_mode ? 8'h01 : 8'(a[7:0] * 8'd3 + a[15:8] + 8'(k * 29) + salt);
    end
    return w;
  endfunction

  function automatic logic [31:0] byte_sum(input logic [WORD_W-1:0] w);
    logic [31:0] s = 32'd0;
    for (int k = 0; k < WH * WW; k++) s += 32'(w[k*8 +: 8]);
    return s;
  endfunction

  // weight memory: one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_fn(bus.mem_addr);
    cyc       <= cyc + 1;
    full_edge <= |bus.weight_buffer_full;
  end

  always @(negedge clk) begin
    full_rnd <= (rand_full && ($urandom_range(0, 2) == 0)) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
  end

  // monitor: pops expectations whenever the DUT reads or writes
  always @(negedge clk) begin
    int rel;
    logic [WORD_W-1:0] d;
    rel = cyc - start_cyc;
    if (rst) begin
      if (bus.weight_buffer_wren != 4'd0) chk("wren_in_reset", 128'(bus.weight_buffer_wren), 128'd0);
    end else begin
      if (bus.mem_rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = rel;
        last_rd = rel;
        if (exp_rd_q.size() == 0) chk("rd_queue_level", 128'(exp_rd_q.size()), 128'd1);
        else chk("rd_addr", 128'(bus.mem_addr), 128'(exp_rd_q.pop_front()));
      end
      if (bus.weight_buffer_wren != 4'd0) begin
        n_wr++;
        if (first_wr < 0) first_wr = rel;
        last_wr = rel;
        if (rel >= 6 && rel <= 10) stall_wr++;
        chk("wren_all_rows", 128'(bus.weight_buffer_wren), 128'hF);
        chk("wren_after_full", 128'(full_edge), 128'd0);
        d = bus.weight_buffer_din;
        if (exp_wr_q.size() == 0) chk("wr_queue_level", 128'(exp_wr_q.size()), 128'd1);
        else chk("wr_data", 128'(d), 128'(exp_wr_q.pop_front()));
      end
      if (done) begin
        done_rel = rel;
        chk("busy_at_done", 128'(busy), 128'd1);
`ifdef WLOAD_CHECKSUM_EN
        chk("checksum", 128'(checksum), 128'(exp_cs));
`endif
      end
    end
  end

  task automatic start_run(input logic [15:0] b, input logic [15:0] ng, input logic [15:0] np);
    logic [15:0] a;
    @(negedge clk); #2;
    start_cyc = cyc;
    n_rd = 0; n_wr = 0; first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
    done_rel = -1; stall_wr = 0; exp_cs = 32'd0;
    for (int p = 0; p < int'(np); p++)
      for (int g = 0; g < int'(ng); g++)
        for (int w = 0; w < GW; w++) begin
          a = 16'(int'(b) + g * GW + w);
          exp_rd_q.push_back(a);
          exp_wr_q.push_back(mem_fn(a));
          exp_cs += byte_sum(mem_fn(a));
        end
    start = 1'b1; base_addr = b; num_groups = ng; num_passes = np;
    @(negedge clk); #2;
    start = 1'b0;
    base_addr = 16'($urandom); num_groups = 16'($urandom); num_passes = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_rel < 0; i++) @(posedge clk);
    chk("done_seen", 128'(done_rel >= 0), 128'd1);
    repeat (3) @(posedge clk);
    chk("rd_expect_drained", 128'(exp_rd_q.size()), 128'd0);
    chk("wr_expect_drained", 128'(exp_wr_q.size()), 128'd0);
  endtask

  task automatic wait_rel(input int r);
    while (cyc - start_cyc < r) @(negedge clk);
    #2;
  endtask

  initial begin
    int total;
    logic [15:0] b, ng, np;
    salt = 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 128'(bus.mem_rd_en), 128'd0);
    chk("rst_addr", 128'(bus.mem_addr), 128'd0);
    chk("rst_wren", 128'(bus.weight_buffer_wren), 128'd0);
    chk("rst_din", 128'(bus.weight_buffer_din), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic 2 groups, 1 pass
    start_run(16'h0010, 16'd2, 16'd1);
    wait_done(200);
    chk("t1_first_rd", 128'(first_rd), 128'd1);
    chk("t1_last_rd", 128'(last_rd), 128'd8);
    chk("t1_n_rd", 128'(n_rd), 128'd8);
    chk("t1_first_wr", 128'(first_wr), 128'd3);
    chk("t1_last_wr", 128'(last_wr), 128'd10);
    chk("t1_n_wr", 128'(n_wr), 128'd8);
    chk("t1_done", 128'(done_rel), 128'd11);
    chk("t1_busy_after", 128'(busy), 128'd0);

    // three passes replay the same addresses without a bubble
    start_run(16'h0010, 16'd1, 16'd3);
    wait_done(200);
    chk("t2_n_wr", 128'(n_wr), 128'd12);
    chk("t2_contig", 128'(last_wr - first_wr + 1), 128'd12);
    chk("t2_done", 128'(done_rel), 128'd15);

    // full[2] held for cycles 5..9
    start_run(16'h0010, 16'd2, 16'd1);
    wait_rel(5); full_dir = 4'b0100;
    wait_rel(10); full_dir = 4'b0000;
    wait_done(200);
    chk("t3_stall_wr", 128'(stall_wr), 128'd0);
    chk("t3_n_wr", 128'(n_wr), 128'd8);
    chk("t3_resume", 128'(last_wr), 128'd15);
    chk("t3_done", 128'(done_rel), 128'd16);

    // zero-size layers
    start_run(16'h0010, 16'd0, 16'd2);
    wait_done(50);
    chk("t4_done", 128'(done_rel), 128'd1);
    chk("t4_n_rd", 128'(n_rd), 128'd0);
    start_run(16'h0030, 16'd3, 16'd0);
    wait_done(50);
    chk("t4b_done", 128'(done_rel), 128'd1);
    chk("t4b_n_wr", 128'(n_wr), 128'd0);

    // reset mid-run, then restart from word 0
    start_run(16'h0010, 16'd2, 16'd1);
    wait_rel(6);
    rst = 1'b1;
    #1;
    chk("t5_rd_en", 128'(bus.mem_rd_en), 128'd0);
    chk("t5_addr", 128'(bus.mem_addr), 128'd0);
    chk("t5_wren", 128'(bus.weight_buffer_wren), 128'd0);
    chk("t5_din", 128'(bus.weight_buffer_din), 128'd0);
    chk("t5_busy", 128'(busy), 128'd0);
    exp_rd_q.delete(); exp_wr_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    start_run(16'h0010, 16'd2, 16'd1);
    wait_done(200);
    chk("t5_first_rd", 128'(first_rd), 128'd1);
    chk("t5_n_wr", 128'(n_wr), 128'd8);
    chk("t5_done", 128'(done_rel), 128'd11);

    // start while busy is ignored
    start_run(16'h0020, 16'd1, 16'd2);
    wait_rel(3);
    start = 1'b1; num_groups = 16'd5; num_passes = 16'd5; base_addr = 16'h0400;
    @(negedge clk); #2 start = 1'b0;
    wait_done(200);
    chk("t6_n_wr", 128'(n_wr), 128'd8);
    chk("t6_done", 128'(done_rel), 128'd11);

    // randomised sizes, bases (incl. address wrap) and backpressure
    for (int it = 0; it < 10; it++) begin
      b  = (it % 3 == 0) ? 16'hFFFA : 16'($urandom);
      ng = 16'($urandom_range(1, 3));
      np = 16'($urandom_range(1, 3));
      total = int'(ng) * int'(np) * GW;
      rand_full = 1'b1;
      start_run(b, ng, np);
      wait_done(1000);
      rand_full = 1'b0;
      chk("rand_n_wr", 128'(n_wr), 128'(total));
      chk("rand_n_rd", 128'(n_rd), 128'(total));
      repeat (2) @(negedge clk);
    end

`ifdef WLOAD_CHECKSUM_EN
    ones_mode = 1'b1;
    start_run(16'h0010, 16'd2, 16'd1);
    wait_done(200);
    chk("cs_ones", 128'(checksum), 128'd96);
    ones_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
